// File: rtl/ras.sv
// ras: circular return address stack with checkpoint restore for the fetch predictor.
module ras #(
  parameter int RAS_ENTRIES = 8,
  parameter int RAS_INDEX_WIDTH = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [RAS_TARGET_WIDTH-1:0] ras_link_pc,
  input  logic                        ras_push,
  input  logic                        ras_pop,
  output logic [RAS_TARGET_WIDTH-1:0] ras_ret_pc,
  output logic                        ras_ret_valid,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count,
  input  logic                        ras_restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  ras_restore_index,
  input  logic [RAS_INDEX_WIDTH:0]    ras_restore_count
);
  localparam logic [RAS_INDEX_WIDTH:0] full = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
  localparam logic [RAS_INDEX_WIDTH-1:0] one_i = 1;
  localparam logic [RAS_INDEX_WIDTH:0] one_c = 1;
  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0] ptr;
  logic [RAS_INDEX_WIDTH:0] count;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr <= '0;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) entries[i] <= '0;
    end else if (ras_restore_valid) begin
      ptr <= ras_restore_index;
      count <= (ras_restore_count > full) ? full : ras_restore_count;
    end else if (ras_push && ras_pop) begin
      entries[ptr] <= ras_link_pc;
    end else if (ras_push) begin
      entries[ptr + one_i] <= ras_link_pc;
      ptr <= ptr + one_i;
      count <= (count == full) ? full : count + one_c;
    end else if (ras_pop) begin
      ptr <= ptr - one_i;
      count <= (count == '0) ? '0 : count - one_c;
    end
  end
  always_comb begin
    ras_ret_pc = entries[ptr];
    ras_ret_valid = count != '0;
    ras_index = ptr;
    ras_count = count;
  end
endmodule

// File: doc/ras.md
# ras

Return address stack for the fetch predictor stage. Fetch pushes the link PC (PC+2/4 with the low bit dropped) on calls and pops a predicted return target on returns. The ROB/branch-mispredict path restores the stack pointer and occupancy to a checkpointed state. It is a circular 8-entry stack: overflow overwrites the oldest entry and never stalls fetch.

## Interface
Parameters:
- RAS_ENTRIES, 8, stack depth (power of 2)
- RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES) = 3, pointer width
- RAS_TARGET_WIDTH, 31, stored target width (PC[31:1])

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous, active-low reset; sampled on rising CLK
- ras_link_pc  in  RAS_TARGET_WIDTH  link address to push
- ras_push  in  1  call: push ras_link_pc
- ras_pop  in  1  return: pop top entry
- ras_ret_pc  out  RAS_TARGET_WIDTH  current top entry (predicted return target)
- ras_ret_valid  out  1  top entry holds a pushed value (count != 0)
- ras_index  out  RAS_INDEX_WIDTH  current top pointer, checkpointed by fetch per prediction
- ras_count  out  RAS_INDEX_WIDTH+1  current occupancy, 0..RAS_ENTRIES, checkpointed with ras_index
- ras_restore_valid  in  1  mispredict restore request
- ras_restore_index  in  RAS_INDEX_WIDTH  pointer to restore
- ras_restore_count  in  RAS_INDEX_WIDTH+1  occupancy to restore; values above RAS_ENTRIES are clamped to RAS_ENTRIES

## Operation
- State: entries[RAS_ENTRIES] of RAS_TARGET_WIDTH, ptr (RAS_INDEX_WIDTH), count (RAS_INDEX_WIDTH+1).
- Reset (nRST=0 at edge): ptr=0, count=0, all entries=0. Outputs after reset: ras_ret_pc=0, ras_ret_valid=0, ras_index=0, ras_count=0.
- ras_ret_pc = entries[ptr]; ras_ret_valid = (count != 0); ras_index = ptr; ras_count = count.
- Push entries are stored at ptr+1. Reads come from entries[ptr]. Slot ptr is the top of stack.
- Update priority per cycle: restore > (push and pop) > push > pop > hold.
- Restore: ptr <= ras_restore_index; count <= min(ras_restore_count, RAS_ENTRIES). Entries are not modified. Any same-cycle push/pop is ignored.
- Push only:
  - entries[ptr+1] <= ras_link_pc; ptr <= ptr+1, modulo RAS_ENTRIES.
  - count <= count+1, saturating at RAS_ENTRIES.
  - When full, the oldest entry is overwritten silently.
- Pop only:
  - ptr <= ptr-1, modulo RAS_ENTRIES (wraps 0 -> 7).
  - count <= count-1, saturating at 0.
  - On underflow (count=0), ptr still decrements, ras_ret_valid stays 0, and the returned value is stale.
- Push and pop together (jalr link-swap): entries[ptr] <= ras_link_pc; ptr and count are unchanged. The popped value presented this cycle is the pre-write entries[ptr].
- All arithmetic on ptr is modulo 2^RAS_INDEX_WIDTH. The count compare uses RAS_INDEX_WIDTH+1 bits.

## Timing
- ras_ret_pc, ras_ret_valid, ras_index and ras_count are combinational from registered state only; there is no input-to-output combinational path.
- A pop in cycle N consumes the ras_ret_pc shown in cycle N. The next top is visible in cycle N+1.
- Push in cycle N: the pushed value appears on ras_ret_pc in cycle N+1.
- Restore in cycle N: the restored ptr/count are visible in cycle N+1. One-cycle recovery.
- Back-to-back push/pop/restore every cycle is supported. There is no busy state and no backpressure.
- Reset asserted mid-operation overrides restore/push/pop in that cycle.

## Test plan
- Reset then idle: ras_ret_valid=0, ras_index=0, ras_count=0, ras_ret_pc=0. A pop in this state gives ras_index=7 and ras_count=0 the next cycle.
- Push 0x100, 0x200, 0x300 on consecutive cycles, then pop three times: the pops see 0x300, 0x200, 0x100 with valid=1. After that, count=0 and ras_index=0.
- Push 9 values 0x1..0x9: count saturates at 8 and ras_index=1. Popping 8 times returns 0x9..0x2. A further pop shows valid=0.
- With top 0x200 and count=2, assert push(0x555) and pop together: that cycle ras_ret_pc=0x200. The next cycle ras_ret_pc=0x555, and count and index are unchanged.
- Checkpoint ras_index=2 and count=2, push twice, then assert restore(2,2) together with push(0xAAA): the next cycle ras_index=2, count=2, and ras_ret_pc equals the pre-push top. 0xAAA is not written.
- Assert nRST=0 in the same cycle as a push after 5 pushes: the next cycle all outputs are 0.
